// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register.
package pipe_pkg;

    // Occupancy of a stage: nothing held, main entry held, main + skid held.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    // Default payload widths of the classic five-stage pipeline registers.
    localparam int IF_ID_DATA_W  = 64;   // PC 32 + Instr 32
    localparam int ID_EX_DATA_W  = 101;  // RD1 32 + RD2 32 + Imm 32 + RD 5
    localparam int EX_MEM_DATA_W = 69;   // ALU 32 + WriteData 32 + RD 5
    localparam int MEM_WB_DATA_W = 69;   // ReadData 32 + ALU 32 + RD 5

    // Value every control bit takes in a bubble.
    localparam logic CTRL_BUBBLE = 1'b0;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline stage: valid flag, control and payload.
// Clear drops the entry and zeroes control but keeps the payload bits.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 69
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // Next-entry selection: clear beats load, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            ctrl_d  = {CTRL_W{CTRL_BUBBLE}};
        end else if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= {CTRL_W{1'b0}};
            data_q  <= {DATA_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush with
// bubble insertion, optional skid entry and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W  = 2,
    parameter int DATA_W  = 69,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    pipe_state_e       state_q, state_d;
    logic              main_v, skid_v;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
    logic [DATA_W-1:0] main_data, skid_data, main_data_in;
    logic              main_load, main_clr, main_from_skid;
    logic              skid_load, skid_clr;
    logic              in_xfer, out_xfer;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    // With a skid entry ready depends only on registered state; without it
    // the stage can take a beat whenever its single entry drains this cycle.
    assign ready_o  = (SKID_EN != 0) ? (rst_i & ~skid_v)
                                     : (rst_i & (ready_i | ~main_v));
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = main_v & ready_i;

    // Occupancy transitions and slot load/clear strobes.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush_i) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_load = 1'b1;
                        state_d   = ST_FULL;
                    end else begin
                        state_d   = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer && in_xfer) begin
                        main_load = 1'b1;
                    end else if (out_xfer) begin
                        main_clr  = 1'b1;
                        state_d   = ST_EMPTY;
                    end else if (in_xfer && (SKID_EN != 0)) begin
                        skid_load = 1'b1;
                        state_d   = ST_SKID;
                    end else begin
                        state_d   = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_d        = ST_FULL;
                    end else begin
                        state_d        = ST_SKID;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // The main entry refills from skid when the older beat leaves.
    assign main_ctrl_in = main_from_skid ? skid_ctrl : ctrl_i;
    assign main_data_in = main_from_skid ? skid_data : data_i;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (main_load),
        .clear_i (main_clr),
        .ctrl_i  (main_ctrl_in),
        .data_i  (main_data_in),
        .valid_o (main_v),
        .ctrl_o  (main_ctrl),
        .data_o  (main_data)
    );

    generate
        if (SKID_EN != 0) begin : g_skid
            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .load_i  (skid_load),
                .clear_i (skid_clr),
                .ctrl_i  (ctrl_i),
                .data_i  (data_i),
                .valid_o (skid_v),
                .ctrl_o  (skid_ctrl),
                .data_o  (skid_data)
            );
        end else begin : g_no_skid
            assign skid_v    = 1'b0;
            assign skid_ctrl = {CTRL_W{1'b0}};
            assign skid_data = {DATA_W{1'b0}};
        end
    endgenerate

    // Saturating count of cycles where a beat waits on downstream.
    always_comb begin
        if (main_v && !ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register; flush deliberately leaves it untouched.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign valid_o     = main_v;
    assign ctrl_o      = main_v ? main_ctrl : {CTRL_W{CTRL_BUBBLE}};
    assign data_o      = main_data;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: instance A uses defaults (skid on, 16-bit counter),
// instance B has no skid entry and a 4-bit counter.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A
    logic        a_rst = 1'b0, a_valid_i = 1'b0, a_flush_i = 1'b0, a_ready_i = 1'b0;
    logic [1:0]  a_ctrl_i = 2'b00;
    logic [68:0] a_data_i = 69'h0;
    logic        a_ready_o, a_valid_o;
    logic [1:0]  a_ctrl_o;
    logic [68:0] a_data_o;
    logic [15:0] a_stall;

    // Instance B
    logic        b_rst = 1'b0, b_valid_i = 1'b0, b_flush_i = 1'b0, b_ready_i = 1'b0;
    logic [1:0]  b_ctrl_i = 2'b01;
    logic [7:0]  b_data_i = 8'h0;
    logic        b_ready_o, b_valid_o;
    logic [1:0]  b_ctrl_o;
    logic [7:0]  b_data_o;
    logic [3:0]  b_stall;

    pipe_stage_reg u_dut_a (
        .clk_i(clk), .rst_i(a_rst), .valid_i(a_valid_i), .ready_o(a_ready_o),
        .ctrl_i(a_ctrl_i), .data_i(a_data_i), .flush_i(a_flush_i),
        .valid_o(a_valid_o), .ready_i(a_ready_i), .ctrl_o(a_ctrl_o),
        .data_o(a_data_o), .stall_cnt_o(a_stall)
    );

    pipe_stage_reg #(.CTRL_W(2), .DATA_W(8), .SKID_EN(0), .CNT_W(4)) u_dut_b (
        .clk_i(clk), .rst_i(b_rst), .valid_i(b_valid_i), .ready_o(b_ready_o),
        .ctrl_i(b_ctrl_i), .data_i(b_data_i), .flush_i(b_flush_i),
        .valid_o(b_valid_o), .ready_i(b_ready_i), .ctrl_o(b_ctrl_o),
        .data_o(b_data_o), .stall_cnt_o(b_stall)
    );

    // Apply A inputs on the falling edge, then settle before sampling.
    task automatic a_drive(input logic r, input logic v, input logic [1:0] c,
                           input logic [68:0] d, input logic f, input logic rdy);
        @(negedge clk);
        a_rst = r; a_valid_i = v; a_ctrl_i = c; a_data_i = d; a_flush_i = f; a_ready_i = rdy;
        #1;
    endtask

    task automatic b_drive(input logic r, input logic v, input logic [7:0] d, input logic rdy);
        @(negedge clk);
        b_rst = r; b_valid_i = v; b_data_i = d; b_ready_i = rdy; b_flush_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        a_drive(1'b0, 1'b1, 2'b11, 69'h99, 1'b0, 1'b1);
        checks++; if (a_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", a_ready_o); end
        a_drive(1'b0, 1'b1, 2'b11, 69'h99, 1'b0, 1'b1);
        checks++; if (a_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b want 0", a_ready_o); end
        checks++; if (a_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_valid_o); end
        checks++; if (a_ctrl_o !== 2'b00) begin errors++; $display("FAIL reset_ctrl: got %b want 00", a_ctrl_o); end
        checks++; if (a_data_o !== 69'h0) begin errors++; $display("FAIL reset_data: got %h want 0", a_data_o); end
        checks++; if (a_stall !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", a_stall); end
    endtask

    task automatic test_stream();
        for (int k = 1; k <= 5; k++) begin
            a_drive(1'b1, 1'b1, 2'b01, 69'(k), 1'b0, 1'b1);
            checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b want 1", k, a_ready_o); end
            if (k > 1) begin
                checks++; if (a_valid_o !== 1'b1 || a_data_o !== 69'(k - 1))
                    begin errors++; $display("FAIL stream_data[%0d]: got v=%b d=%h want v=1 d=%h", k, a_valid_o, a_data_o, k - 1); end
            end
        end
        a_drive(1'b1, 1'b0, 2'b00, 69'h0, 1'b0, 1'b1);
        checks++; if (a_valid_o !== 1'b1 || a_data_o !== 69'h5 || a_ctrl_o !== 2'b01)
            begin errors++; $display("FAIL stream_last: got v=%b d=%h c=%b want v=1 d=5 c=01", a_valid_o, a_data_o, a_ctrl_o); end
        a_drive(1'b1, 1'b0, 2'b00, 69'h0, 1'b0, 1'b1);
        checks++; if (a_valid_o !== 1'b0 || a_ctrl_o !== 2'b00)
            begin errors++; $display("FAIL stream_drain: got v=%b c=%b want v=0 c=00", a_valid_o, a_ctrl_o); end
        checks++; if (a_stall !== 16'd0) begin errors++; $display("FAIL stream_stall: got %0d want 0", a_stall); end
    endtask

    task automatic test_backpressure();
        a_drive(1'b1, 1'b1, 2'b01, 69'hA, 1'b0, 1'b0);
        checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_a: got %b want 1", a_ready_o); end
        a_drive(1'b1, 1'b1, 2'b01, 69'hB, 1'b0, 1'b0);
        checks++; if (a_ready_o !== 1'b1 || a_data_o !== 69'hA)
            begin errors++; $display("FAIL bp_full: got r=%b d=%h want r=1 d=a", a_ready_o, a_data_o); end
        a_drive(1'b1, 1'b0, 2'b00, 69'h0, 1'b0, 1'b0);
        checks++; if (a_ready_o !== 1'b0 || a_data_o !== 69'hA || a_stall !== 16'd1)
            begin errors++; $display("FAIL bp_skid: got r=%b d=%h s=%0d want r=0 d=a s=1", a_ready_o, a_data_o, a_stall); end
        a_drive(1'b1, 1'b0, 2'b00, 69'h0, 1'b0, 1'b1);
        checks++; if (a_ready_o !== 1'b0 || a_data_o !== 69'hA || a_stall !== 16'd2)
            begin errors++; $display("FAIL bp_hold: got r=%b d=%h s=%0d want r=0 d=a s=2", a_ready_o, a_data_o, a_stall); end
        a_drive(1'b1, 1'b0, 2'b00, 69'h0, 1'b0, 1'b1);
        checks++; if (a_valid_o !== 1'b1 || a_data_o !== 69'hB || a_ready_o !== 1'b1)
            begin errors++; $display("FAIL bp_second: got v=%b d=%h r=%b want v=1 d=b r=1", a_valid_o, a_data_o, a_ready_o); end
        a_drive(1'b1, 1'b0, 2'b00, 69'h0, 1'b0, 1'b1);
        checks++; if (a_valid_o !== 1'b0 || a_stall !== 16'd2)
            begin errors++; $display("FAIL bp_empty: got v=%b s=%0d want v=0 s=2", a_valid_o, a_stall); end
    endtask

    task automatic test_flush();
        a_drive(1'b1, 1'b1, 2'b01, 69'hC, 1'b0, 1'b0);
        a_drive(1'b1, 1'b1, 2'b01, 69'hD, 1'b0, 1'b0);
        a_drive(1'b1, 1'b1, 2'b01, 69'hE, 1'b1, 1'b0);
        checks++; if (a_ready_o !== 1'b0 || a_data_o !== 69'hC)
            begin errors++; $display("FAIL flush_pre: got r=%b d=%h want r=0 d=c", a_ready_o, a_data_o); end
        a_drive(1'b1, 1'b0, 2'b00, 69'h0, 1'b0, 1'b1);
        checks++; if (a_valid_o !== 1'b0 || a_ctrl_o !== 2'b00 || a_ready_o !== 1'b1 || a_data_o !== 69'hC)
            begin errors++; $display("FAIL flush_skid: got v=%b c=%b r=%b d=%h want v=0 c=00 r=1 d=c", a_valid_o, a_ctrl_o, a_ready_o, a_data_o); end
        checks++; if (a_stall !== 16'd4) begin errors++; $display("FAIL flush_stall: got %0d want 4", a_stall); end
        a_drive(1'b1, 1'b1, 2'b10, 69'hF0, 1'b0, 1'b1);
        a_drive(1'b1, 1'b1, 2'b10, 69'hE, 1'b1, 1'b1);
        checks++; if (a_valid_o !== 1'b1 || a_data_o !== 69'hF0 || a_ctrl_o !== 2'b10)
            begin errors++; $display("FAIL flush_full_pre: got v=%b d=%h c=%b want v=1 d=f0 c=10", a_valid_o, a_data_o, a_ctrl_o); end
        a_drive(1'b1, 1'b0, 2'b00, 69'h0, 1'b0, 1'b1);
        checks++; if (a_valid_o !== 1'b0 || a_data_o !== 69'hF0 || a_ctrl_o !== 2'b00)
            begin errors++; $display("FAIL flush_discard: got v=%b d=%h c=%b want v=0 d=f0 c=00", a_valid_o, a_data_o, a_ctrl_o); end
        a_drive(1'b1, 1'b0, 2'b00, 69'h0, 1'b0, 1'b1);
        checks++; if (a_valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_e: got v=%b want 0", a_valid_o); end
    endtask

    task automatic test_bubble();
        a_drive(1'b1, 1'b1, 2'b11, 69'h77, 1'b0, 1'b1);
        a_drive(1'b1, 1'b0, 2'b00, 69'h0, 1'b0, 1'b1);
        checks++; if (a_ctrl_o !== 2'b11 || a_valid_o !== 1'b1 || a_data_o !== 69'h77)
            begin errors++; $display("FAIL bubble_live: got c=%b v=%b d=%h want c=11 v=1 d=77", a_ctrl_o, a_valid_o, a_data_o); end
        a_drive(1'b1, 1'b0, 2'b00, 69'h0, 1'b0, 1'b1);
        checks++; if (a_ctrl_o !== 2'b00 || a_valid_o !== 1'b0 || a_data_o !== 69'h77)
            begin errors++; $display("FAIL bubble_gate: got c=%b v=%b d=%h want c=00 v=0 d=77", a_ctrl_o, a_valid_o, a_data_o); end
    endtask

    task automatic test_comb_ready();
        b_drive(1'b1, 1'b1, 8'h1, 1'b1);
        checks++; if (b_ready_o !== 1'b1) begin errors++; $display("FAIL comb_ready_empty: got %b want 1", b_ready_o); end
        b_drive(1'b1, 1'b1, 8'h2, 1'b1);
        checks++; if (b_ready_o !== 1'b1 || b_valid_o !== 1'b1 || b_data_o !== 8'h1)
            begin errors++; $display("FAIL comb_beat1: got r=%b v=%b d=%h want r=1 v=1 d=01", b_ready_o, b_valid_o, b_data_o); end
        b_drive(1'b1, 1'b1, 8'h3, 1'b0);
        checks++; if (b_ready_o !== 1'b0 || b_data_o !== 8'h2)
            begin errors++; $display("FAIL comb_ready_low: got r=%b d=%h want r=0 d=02", b_ready_o, b_data_o); end
        b_drive(1'b1, 1'b1, 8'h3, 1'b1);
        checks++; if (b_ready_o !== 1'b1 || b_data_o !== 8'h2 || b_stall !== 4'd1)
            begin errors++; $display("FAIL comb_ready_high: got r=%b d=%h s=%0d want r=1 d=02 s=1", b_ready_o, b_data_o, b_stall); end
        b_drive(1'b1, 1'b0, 8'h0, 1'b1);
        checks++; if (b_valid_o !== 1'b1 || b_data_o !== 8'h3)
            begin errors++; $display("FAIL comb_beat3: got v=%b d=%h want v=1 d=03", b_valid_o, b_data_o); end
        b_drive(1'b1, 1'b0, 8'h0, 1'b1);
        checks++; if (b_valid_o !== 1'b0 || b_ready_o !== 1'b1)
            begin errors++; $display("FAIL comb_drain: got v=%b r=%b want v=0 r=1", b_valid_o, b_ready_o); end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        b_drive(1'b1, 1'b1, 8'h9, 1'b0);
        for (int i = 0; i < 20; i++) begin
            b_drive(1'b1, 1'b0, 8'h0, 1'b0);
            exp_cnt = (i + 1 > 15) ? 15 : i + 1;
            checks++; if (b_valid_o !== 1'b1 || b_stall !== 4'(exp_cnt))
                begin errors++; $display("FAIL sat_cnt[%0d]: got v=%b s=%0d want v=1 s=%0d", i, b_valid_o, b_stall, exp_cnt); end
        end
        b_drive(1'b0, 1'b0, 8'h0, 1'b0);
        checks++; if (b_stall !== 4'd15 || b_ready_o !== 1'b0)
            begin errors++; $display("FAIL sat_hold: got s=%0d r=%b want s=15 r=0", b_stall, b_ready_o); end
        b_drive(1'b1, 1'b0, 8'h0, 1'b0);
        checks++; if (b_stall !== 4'd0 || b_valid_o !== 1'b0 || b_ready_o !== 1'b1)
            begin errors++; $display("FAIL sat_reset: got s=%0d v=%b r=%b want s=0 v=0 r=1", b_stall, b_valid_o, b_ready_o); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_bubble();
        b_drive(1'b0, 1'b0, 8'h0, 1'b0);
        test_comb_ready();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic parametrised pipeline stage register. It replaces the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block that adds valid/ready handshaking, stall via backpressure, flush with bubble insertion, and an optional skid slot that cuts the combinational ready path. Control bits are separated from payload so that a bubble always presents zeroed control (e.g. RegWrite=0, MemWrite=0) downstream.

Parameters:
CTRL_W, 2, width of control field; forced to 0 on bubble, flush and reset.
DATA_W, 69, width of payload field (e.g. ReadData 32 + ALU 32 + RD 5); never forced, only held.
SKID_EN, 1, 1 = two-entry (main + skid) with registered ready_o; 0 = single entry with combinational ready_o.
CNT_W, 16, width of saturating stall-cycle counter.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  synchronous reset, active low.
valid_i  in  1  upstream beat valid.
ready_o  out  1  stage can accept a beat.
ctrl_i  in  CTRL_W  upstream control bits.
data_i  in  DATA_W  upstream payload.
flush_i  in  1  discard all held and incoming beats this cycle.
valid_o  out  1  downstream beat valid.
ready_i  in  1  downstream accepts.
ctrl_o  out  CTRL_W  control bits, equal to 0 whenever valid_o=0.
data_o  out  DATA_W  payload from main entry.
stall_cnt_o  out  CNT_W  cycles with valid_o=1 and ready_i=0, saturating.

Behaviour:
- Transfer in: valid_i & ready_o at the clock edge. Transfer out: valid_o & ready_i at the clock edge.
- Reset (rst_i=0 at edge): main_v=0, skid_v=0, ctrl regs=0, data regs=0, stall_cnt=0. ready_o is forced 0 while rst_i=0 and is 1 in the first cycle after release. Inputs are ignored during reset.
- Output gating: ctrl_o = main_v ? ctrl_q : 0. data_o = data_q, not gated.
- Latency: 1 cycle from accepted input to valid_o, in both modes.
- SKID_EN=0:
  - ready_o = rst_i & (ready_i | ~main_v).
  - On in-transfer, main loads ctrl_i/data_i and main_v becomes 1.
  - On out-transfer without in-transfer, main_v becomes 0 and data is held.
- SKID_EN=1: ready_o = rst_i & ~skid_v (registered). States:
  - EMPTY (main_v=0, skid_v=0): an in-transfer loads main and moves to FULL.
  - FULL (main_v=1, skid_v=0):
    - out and in: main reloads, stays FULL.
    - out only: moves to EMPTY.
    - in only: incoming beat goes to skid, moves to SKID.
    - neither: holds.
  - SKID (both valid, ready_o=0): on out, skid moves to main, skid_v becomes 0, moves to FULL. Otherwise holds.
  - Order is preserved: main is always older than skid.
- Flush (flush_i=1, rst_i=1): next state EMPTY, main_v=skid_v=0, ctrl regs=0, data regs held. An in-transfer in the same cycle is discarded. An out-transfer in the same cycle still counts as delivered downstream. Priority is reset > flush > normal.
- stall_cnt_o increments each cycle with valid_o & ~ready_i and saturates at 2^CNT_W-1. It is not cleared by flush.
- Widths: CTRL_W ≥ 1, DATA_W ≥ 1. No arithmetic on the payload.

Decomposition:
- Shared package pipe_pkg:
  - state enum {ST_EMPTY, ST_FULL, ST_SKID}
  - default widths constants (MEM_WB_DATA_W=69, EX_MEM_DATA_W, ...)
  - CTRL_BUBBLE = 0
- Sub-module pipe_slot: one entry (valid + ctrl + data regs) with load, clear and hold. It is instantiated once for main and once for skid (generate on SKID_EN).
- Counter stays inline.

Test Plan:
- Reset then stream: rst_i=0 for 2 cycles, then valid_i=1 with data 0x1..0x5, ready_i=1 -> ready_o=0 during reset. data_o shows 0x1..0x5 one cycle later, valid_o continuous, stall_cnt_o=0.
- Backpressure (SKID_EN=1): send 0xA then 0xB while ready_i=0 -> state SKID, ready_o=0 from the cycle after 0xB. Raise ready_i -> outputs 0xA then 0xB in order, no loss or duplicate. stall_cnt_o equals the number of held cycles.
- Flush with simultaneous input: state SKID holding 0xC, 0xD; flush_i=1 with valid_i=1 carrying 0xE -> next cycle valid_o=0, ctrl_o=0, ready_o=1, and 0xE never appears.
- Bubble gating: CTRL_W=2, ctrl_i=2'b11 accepted then valid_i=0 and ready_i=1 -> ctrl_o=2'b11 for one cycle, then 2'b00 while data_o still holds the old payload.
- SKID_EN=0 combinational ready: main_v=1, ready_i toggles 1/0/1 -> ready_o follows ready_i in the same cycle, throughput is 1 beat per cycle when ready_i=1.
- Counter saturation: CNT_W=4, hold valid_o=1 with ready_i=0 for 20 cycles -> stall_cnt_o=15 and stays 15. Reset mid-hold -> 0, and valid_o=0 on the next cycle.
